// File: rtl/ft245_arbiter.sv
// Two-client arbiter and bus sequencer for the FT245BM USB FIFO.
// Owns nRD/WR/D and runs complete FT245 read and write cycles on behalf of
// two byte-level clients. Arbitration is round-robin with an optional lock
// that keeps ownership across back-to-back transactions.
module ft245_arbiter #(
  parameter int unsigned RD_PULSE = 3,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       nRXF,
  input  logic       nTXE,
  output logic       nRD,
  output logic       WR,
  inout  wire  [7:0] D,
  input  logic [1:0] REQ_RD,
  input  logic [1:0] REQ_WR,
  input  logic [7:0] WDATA0,
  input  logic [7:0] WDATA1,
  input  logic [1:0] LOCK,
  output logic [1:0] GNT,
  output logic [7:0] RDATA,
  output logic [1:0] RVALID,
  output logic [1:0] WDONE
);

  typedef enum logic [2:0] {
    StIdle,
    StRdStrobe,
    StRdDone,
    StWrSetup,
    StWrStrobe,
    StWrHold
  } state_e;

  localparam int unsigned CntW = 8;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;   // client served most recently
  logic            lock_q, lock_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            nrd_q, nrd_d;
  logic            wr_q, wr_d;
  logic            oe_q, oe_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      rvalid_q, rvalid_d;
  logic [1:0]      wdone_q, wdone_d;

  logic [1:0]      rd_elig, wr_elig, elig, consider;
  logic            win;

  // Per-client eligibility against the current FIFO flags.
  always_comb begin
    rd_elig = REQ_RD & {2{~nRXF}};
    wr_elig = REQ_WR & {2{~nTXE}};
    elig    = rd_elig | wr_elig;
  end

  // Arbitration, sequencing and phase counting.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    lock_d   = lock_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    consider = elig;
    win      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A held lock restricts arbitration to its owner; once the owner
        // drops LOCK the lock is released and both clients compete now.
        if (lock_q && LOCK[owner_q]) begin
          consider = elig & onehot(owner_q);
        end else begin
          lock_d = 1'b0;
        end
        if (consider == 2'b11) begin
          win = ~last_q;
        end else begin
          win = consider[1];
        end
        if (|consider) begin
          owner_d = win;
          last_d  = win;
          if (rd_elig[win]) begin
            state_d = StRdStrobe;
          end else begin
            state_d = StWrSetup;
            // Latch the byte so a withdrawn request cannot corrupt the cycle.
            dout_d  = win ? WDATA1 : WDATA0;
          end
        end
      end
      StRdStrobe: begin
        if (cnt_q == CntW'(RD_PULSE - 1)) begin
          state_d = StRdDone;
          rdata_d = D;
        end
      end
      StWrSetup: begin
        if (cnt_q == CntW'(WR_SETUP - 1)) state_d = StWrStrobe;
      end
      StWrStrobe: begin
        if (cnt_q == CntW'(WR_PULSE - 1)) state_d = StWrHold;
      end
      StRdDone, StWrHold: begin
        state_d = StIdle;
        lock_d  = LOCK[owner_q];
      end
      default: state_d = StIdle;
    endcase

    cnt_d = (state_d == state_q && state_q != StIdle) ? cnt_q + 1'b1 : '0;
  end

  // Registered pin and handshake values derived from the next state.
  always_comb begin
    nrd_d    = (state_d != StRdStrobe);
    wr_d     = (state_d == StWrStrobe);
    oe_d     = (state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold);
    gnt_d    = (state_d != StIdle || lock_d) ? onehot(owner_d) : 2'b00;
    rvalid_d = (state_d == StRdDone) ? onehot(owner_d) : 2'b00;
    wdone_d  = (state_d == StWrHold) ? onehot(owner_d) : 2'b00;
  end

  // State and output registers; reset aborts any bus cycle at once.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      lock_q   <= 1'b0;
      dout_q   <= 8'h00;
      rdata_q  <= 8'h00;
      nrd_q    <= 1'b1;
      wr_q     <= 1'b0;
      oe_q     <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      wdone_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      lock_q   <= lock_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      nrd_q    <= nrd_d;
      wr_q     <= wr_d;
      oe_q     <= oe_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
    end
  end

  assign D      = oe_q ? dout_q : 8'hzz;
  assign nRD    = nrd_q;
  assign WR     = wr_q;
  assign GNT    = gnt_q;
  assign RDATA  = rdata_q;
  assign RVALID = rvalid_q;
  assign WDONE  = wdone_q;

endmodule

// File: tb/tb_ft245_arbiter.sv
// Bench for ft245_arbiter: a transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ft245_arbiter;

  localparam int unsigned RdPulse = 3;
  localparam int unsigned WrSetup = 1;
  localparam int unsigned WrPulse = 2;
  localparam int unsigned RdLen   = RdPulse + 1;           // T index of RVALID
  localparam int unsigned WrLen   = WrSetup + WrPulse + 1; // T index of WDONE

  logic       CLK;
  logic       RESETn;
  logic       nRXF;
  logic       nTXE;
  logic [1:0] REQ_RD;
  logic [1:0] REQ_WR;
  logic [1:0] LOCK;
  logic [7:0] WDATA0;
  logic [7:0] WDATA1;
  logic [7:0] ft_byte;
  wire        nRD;
  wire        WR;
  wire  [7:0] D;
  wire  [1:0] GNT;
  wire  [7:0] RDATA;
  wire  [1:0] RVALID;
  wire  [1:0] WDONE;

  int checks;
  int fails;

  ft245_arbiter #(
    .RD_PULSE(RdPulse),
    .WR_SETUP(WrSetup),
    .WR_PULSE(WrPulse)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .nRXF   (nRXF),
    .nTXE   (nTXE),
    .nRD    (nRD),
    .WR     (WR),
    .D      (D),
    .REQ_RD (REQ_RD),
    .REQ_WR (REQ_WR),
    .WDATA0 (WDATA0),
    .WDATA1 (WDATA1),
    .LOCK   (LOCK),
    .GNT    (GNT),
    .RDATA  (RDATA),
    .RVALID (RVALID),
    .WDONE  (WDONE)
  );

  // FT245 side: the chip drives the bus while nRD is low. Pull-ups make an
  // undriven bus read as 8'hFF, so "high-Z" is checked as FF.
  assign D = nRD ? 8'hzz : ft_byte;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup pu (D[gi]);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-timeline model ----------------
  // m_k is the cycle index T1.. within the current transaction.
  logic        m_busy, m_rd, m_owner, m_last, m_lock;
  int unsigned m_k;
  logic [7:0]  m_rdata, m_wdata;
  logic [1:0]  m_rd_ok, m_wr_ok, m_cand;
  logic        m_keep, m_win;

  always_comb begin
    m_rd_ok = REQ_RD & ~{nRXF, nRXF};
    m_wr_ok = REQ_WR & ~{nTXE, nTXE};
    m_cand  = m_rd_ok | m_wr_ok;
    m_keep  = m_lock && LOCK[m_owner];
    if (m_keep) m_cand = m_cand & (m_owner ? 2'b10 : 2'b01);
    if (m_cand == 2'b11) m_win = ~m_last;
    else                 m_win = m_cand[1];
  end

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_busy  <= 1'b0;
      m_rd    <= 1'b0;
      m_owner <= 1'b0;
      m_last  <= 1'b1;
      m_lock  <= 1'b0;
      m_k     <= 0;
      m_rdata <= 8'h00;
      m_wdata <= 8'h00;
    end else if (!m_busy) begin
      if (!m_keep) m_lock <= 1'b0;
      if (m_cand != 2'b00) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_owner <= m_win;
        m_last  <= m_win;
        m_rd    <= m_rd_ok[m_win];
        m_wdata <= m_win ? WDATA1 : WDATA0;
      end
    end else begin
      if (m_rd && m_k == RdPulse) m_rdata <= D;
      if (m_k == (m_rd ? RdLen : WrLen)) begin
        m_busy <= 1'b0;
        m_lock <= LOCK[m_owner];
        m_k    <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [1:0] oh;
    logic       exp_nrd;
    oh      = m_owner ? 2'b10 : 2'b01;
    exp_nrd = !(m_busy && m_rd && m_k <= RdPulse);
    check("cyc_gnt", GNT, (m_busy || m_lock) ? oh : 2'b00);
    check("cyc_nrd", nRD, exp_nrd);
    check("cyc_wr", WR, m_busy && !m_rd && m_k > WrSetup && m_k <= WrSetup + WrPulse);
    check("cyc_rvalid", RVALID, (m_busy && m_rd && m_k == RdLen) ? oh : 2'b00);
    check("cyc_wdone", WDONE, (m_busy && !m_rd && m_k == WrLen) ? oh : 2'b00);
    check("cyc_rdata", RDATA, m_rdata);
    if (m_busy && !m_rd) check("cyc_d_drive", D, m_wdata);
    else if (exp_nrd)    check("cyc_d_z", D, 8'hFF);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- Directed scenarios ----------------
  initial begin
    checks  = 0;
    fails   = 0;
    RESETn  = 1'b0;
    nRXF    = 1'b1;
    nTXE    = 1'b1;
    REQ_RD  = 2'b00;
    REQ_WR  = 2'b00;
    LOCK    = 2'b00;
    WDATA0  = 8'h00;
    WDATA1  = 8'h00;
    ft_byte = 8'h00;

    // Reset values.
    @(negedge CLK);
    check("rst_nrd", nRD, 1'b1);
    check("rst_wr", WR, 1'b0);
    check("rst_gnt", GNT, 2'b00);
    check("rst_rvalid", RVALID, 2'b00);
    check("rst_wdone", WDONE, 2'b00);
    check("rst_rdata", RDATA, 8'h00);
    check("rst_d", D, 8'hFF);
    @(posedge CLK);
    #1 RESETn = 1'b1;

    // Single read by client 0.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin nRXF = 1'b0; ft_byte = 8'hA5; REQ_RD = 2'b01; end
      if (c == 5) begin REQ_RD = 2'b00; nRXF = 1'b1; end
      @(negedge CLK);
      if (c == 1) begin check("rd_gnt_t1", GNT, 2'b01); check("rd_nrd_t1", nRD, 1'b0); end
      if (c == 3) check("rd_nrd_t3", nRD, 1'b0);
      if (c == 4) begin
        check("rd_nrd_t4", nRD, 1'b1);
        check("rd_rvalid_t4", RVALID, 2'b01);
        check("rd_rdata_t4", RDATA, 8'hA5);
        check("rd_gnt_t4", GNT, 2'b01);
      end
      if (c == 5) begin check("rd_gnt_t5", GNT, 2'b00); check("rd_rvalid_t5", RVALID, 2'b00); end
    end

    // Client 1 write held off by a full FIFO, then released.
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 0) begin nTXE = 1'b1; WDATA1 = 8'h3C; REQ_WR = 2'b10; end
      if (c == 3) nTXE = 1'b0;
      if (c == 8) begin REQ_WR = 2'b00; nTXE = 1'b1; end
      @(negedge CLK);
      if (c <= 2) begin
        check("wrf_gnt_idle", GNT, 2'b00);
        check("wrf_wr_idle", WR, 1'b0);
        check("wrf_d_idle", D, 8'hFF);
      end
      if (c == 4) begin
        check("wr_d_t1", D, 8'h3C);
        check("wr_wr_t1", WR, 1'b0);
        check("wr_gnt_t1", GNT, 2'b10);
      end
      if (c == 5 || c == 6) check("wr_wr_high", WR, 1'b1);
      if (c == 7) begin
        check("wr_wdone_t4", WDONE, 2'b10);
        check("wr_wr_t4", WR, 1'b0);
        check("wr_d_t4", D, 8'h3C);
      end
      if (c == 8) begin check("wr_d_t5", D, 8'hFF); check("wr_gnt_t5", GNT, 2'b00); end
    end

    // Contention: both clients read continuously; grants alternate.
    for (int c = 0; c < 22; c++) begin
      next_cycle();
      ft_byte = 8'h40 + 8'(c);
      if (c == 0) begin nRXF = 1'b0; REQ_RD = 2'b11; end
      if (c == 20) REQ_RD = 2'b00;
      if (c == 21) nRXF = 1'b1;
      @(negedge CLK);
      if (c == 1)  check("rr_gnt_0", GNT, 2'b01);
      if (c == 6)  check("rr_gnt_1", GNT, 2'b10);
      if (c == 11) check("rr_gnt_2", GNT, 2'b01);
      if (c == 16) check("rr_gnt_3", GNT, 2'b10);
      if (c == 4)  begin check("rr_rvalid_0", RVALID, 2'b01); check("rr_rdata_0", RDATA, 8'h43); end
      if (c == 9)  begin check("rr_rvalid_1", RVALID, 2'b10); check("rr_rdata_1", RDATA, 8'h48); end
      if (c == 14) check("rr_rvalid_2", RVALID, 2'b01);
      if (c == 19) begin check("rr_rvalid_3", RVALID, 2'b10); check("rr_rdata_3", RDATA, 8'h52); end
    end

    // Lock burst: three client-1 writes, then client 0's pending read.
    for (int c = 0; c < 22; c++) begin
      next_cycle();
      if (c == 0)  begin nTXE = 1'b0; WDATA1 = 8'h5A; REQ_WR = 2'b10; LOCK = 2'b10; end
      if (c == 1)  begin nRXF = 1'b0; ft_byte = 8'hE1; REQ_RD = 2'b01; end
      if (c == 15) begin LOCK = 2'b00; REQ_WR = 2'b00; nTXE = 1'b1; end
      if (c == 20) REQ_RD = 2'b00;
      if (c == 21) nRXF = 1'b1;
      @(negedge CLK);
      if (c == 1 || c == 6 || c == 11) check("lk_gnt_wr", GNT, 2'b10);
      if (c == 4 || c == 9 || c == 14) check("lk_wdone", WDONE, 2'b10);
      if (c == 5 || c == 10 || c == 15) check("lk_gnt_held", GNT, 2'b10);
      if (c == 16) check("lk_gnt_rd", GNT, 2'b01);
      if (c == 19) begin check("lk_rvalid", RVALID, 2'b01); check("lk_rdata", RDATA, 8'hE1); end
      if (c == 20) check("lk_gnt_end", GNT, 2'b00);
    end

    // Committed read: request and nRXF withdrawn at T2.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin nRXF = 1'b0; ft_byte = 8'hC3; REQ_RD = 2'b01; end
      if (c == 2) begin REQ_RD = 2'b00; nRXF = 1'b1; end
      @(negedge CLK);
      if (c == 3) check("cm_nrd_t3", nRD, 1'b0);
      if (c == 4) begin check("cm_rvalid_t4", RVALID, 2'b01); check("cm_rdata_t4", RDATA, 8'hC3); end
      if (c == 5 || c == 6) check("cm_gnt_after", GNT, 2'b00);
    end

    // Reset during the WR strobe of a client-0 write.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 0) begin nTXE = 1'b0; WDATA0 = 8'h96; REQ_WR = 2'b01; end
      @(negedge CLK);
      if (c == 1) check("rs_d_t1", D, 8'h96);
      if (c == 2) check("rs_wr_t2", WR, 1'b1);
    end
    #2 RESETn = 1'b0;
    #1;
    check("rs_wr_async", WR, 1'b0);
    check("rs_d_async", D, 8'hFF);
    check("rs_gnt_async", GNT, 2'b00);
    check("rs_rdata_async", RDATA, 8'h00);
    next_cycle();
    REQ_WR = 2'b00;
    nTXE   = 1'b1;
    next_cycle();
    RESETn = 1'b1;

    // After reset the pointer favours client 0 under contention.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin nRXF = 1'b0; ft_byte = 8'h7E; REQ_RD = 2'b11; end
      if (c == 5) begin REQ_RD = 2'b00; nRXF = 1'b1; end
      @(negedge CLK);
      if (c == 1) check("rs_gnt_first", GNT, 2'b01);
      if (c == 4) begin check("rs_rvalid", RVALID, 2'b01); check("rs_rdata", RDATA, 8'h7E); end
      if (c == 5) check("rs_gnt_end", GNT, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
